led_data_sel: RTL and testbench
===============================

// Module: led_data_sel
// PURPOSE
//   Produces the 32-bit LedData word consumed by the 8-digit seven-segment display driver.
//   Keeps CPU run statistics and a syscall display register.
//   A debounced board button selects which statistic is shown.
//   Sits between the pipeline CPU top (status/strobe outputs) and the display driver (LedData input).
// PARAMETERS
//   WIDTH            32  width of LedData, counters and sys_data
//   DEBOUNCE_CYCLES  16  consecutive stable synchronised samples needed to accept a new button level (>=2)
// PORTS
//   clk       in   1      system clock; same clock as the CPU and the display driver
//   rst_n     in   1      asynchronous active-low reset
//   halt      in   1      CPU halted; freezes cycle_cnt and inst_cnt
//   retire    in   1      one-cycle pulse per retired instruction
//   irq_ack   in   1      one-cycle pulse per interrupt accepted by the CPU
//   sys_wr    in   1      syscall display-write strobe
//   sys_data  in   WIDTH  value to show on a syscall write
//   pc        in   WIDTH  current PC, from the WB stage
//   mode_btn  in   1      raw, asynchronous, bouncing push-button
//   LedData   out  WIDTH  registered word to the display driver
//   mode      out  2      current display mode (for board LEDs)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous)
//     - Clears to 0: LedData, mode, cycle_cnt, inst_cnt, irq_cnt, sys_reg, sync flops, debounce counter, debounced level.
//     - Reset may assert mid-count; all state clears immediately.
//   Counters (all WIDTH bits; wrap 2^WIDTH-1 -> 0, no saturation)
//     - cycle_cnt: +1 every clk where halt=0.
//     - inst_cnt: +1 when retire=1 && halt=0. retire together with halt is ignored.
//     - irq_cnt: +1 on irq_ack=1, regardless of halt.
//   sys_reg
//     - Loads sys_data on sys_wr=1, regardless of halt.
//     - sys_wr and its data visible in the same cycle; the last write wins.
//   Button path
//     - mode_btn -> 2-flop synchroniser -> btn_s.
//     - Debounce counter db_cnt:
//         - Resets to 0 whenever btn_s == db_level.
//         - Otherwise increments.
//         - On reaching DEBOUNCE_CYCLES-1 while still different, db_level <= btn_s and db_cnt <= 0.
//     - A 0->1 transition of db_level advances mode: 0->1->2->3->0.
//     - Release (1->0) has no effect.
//     - Glitches shorter than DEBOUNCE_CYCLES cycles are never accepted.
//   Output select, registered (LedData <= sel each clk, latency 1 cycle)
//     - mode 0: sys_reg
//     - mode 1: cycle_cnt
//     - mode 2: inst_cnt
//     - mode 3: {irq_cnt[15:0], pc[15:0]}
//   Update rules
//     - LedData reflects register values from the previous cycle; counter updates appear 2 clks after the event.
//     - A mode change takes effect on LedData in the cycle after mode updates.
//   Outputs are glitch-free: every output is driven straight from a flop.
// TESTING
//   1. Reset: hold rst_n=0 for 5 clks, halt=0 -> LedData=0, mode=0.
//      Release reset, then set mode=1 via the button -> LedData increments by 1 every clk.
//   2. Halt freeze: mode=2, 10 retire pulses with halt=0, then halt=1 with 3 more pulses
//      -> LedData holds 0x0000000A.
//   3. Syscall: sys_wr with sys_data=0xDEADBEEF, then 0x12345678 one clk later, mode 0
//      -> LedData=0x12345678.
//   4. Debounce: mode_btn bounces 0/1 every 3 clks for 40 clks, then stays 1 for 30 clks
//      -> mode goes 0->1 exactly once.
//      Release, then press again -> mode=2.
//   5. Mode 3: 5 irq_ack pulses, pc=0x00003040 -> LedData=0x00053040.
//      Four total presses starting from mode 0 -> wraps to mode 0.
//   6. Wrap: force cycle_cnt=0xFFFFFFFF (hierarchical deposit), mode 1
//      -> next value 0x00000000.
//      Assert rst_n mid-debounce -> mode=0 immediately, no spurious advance after release.

Source files
------------

// File: rtl/led_data_sel.sv
// LedData source selector: CPU run statistics, syscall display register,
// and a debounced mode button that picks which one the display shows.
module led_data_sel #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             retire,
  input  logic             irq_ack,
  input  logic             sys_wr,
  input  logic [WIDTH-1:0] sys_data,
  input  logic [WIDTH-1:0] pc,
  input  logic             mode_btn,
  output logic [WIDTH-1:0] LedData,
  output logic [1:0]       mode
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ?
                       $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX =
    DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    M_SYS  = 2'd0,
    M_CYC  = 2'd1,
    M_INST = 2'd2,
    M_IRQ  = 2'd3
  } mode_e;

  logic [WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [WIDTH-1:0] inst_cnt_q,  inst_cnt_d;
  logic [WIDTH-1:0] irq_cnt_q,   irq_cnt_d;
  logic [WIDTH-1:0] sys_reg_q,   sys_reg_d;
  logic [WIDTH-1:0] led_q,       led_d;
  logic             sync1_q;
  logic             btn_s_q;
  logic [DBW-1:0]   db_cnt_q,    db_cnt_d;
  logic             db_level_q,  db_level_d;
  mode_e            mode_q,      mode_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    irq_cnt_d   = irq_cnt_q;
    sys_reg_d   = sys_reg_q;
    if (!halt) begin
      cycle_cnt_d = cycle_cnt_q + WIDTH'(1);
    end
    if (retire && !halt) begin
      inst_cnt_d = inst_cnt_q + WIDTH'(1);
    end
    if (irq_ack) begin
      irq_cnt_d = irq_cnt_q + WIDTH'(1);
    end
    if (sys_wr) begin
      sys_reg_d = sys_data;
    end
  end

  // New level is accepted only after DEBOUNCE_CYCLES differing samples;
  // only the press edge advances the mode.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    mode_d     = mode_q;
    if (btn_s_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      db_cnt_d   = '0;
      db_level_d = btn_s_q;
      if (btn_s_q) begin
        mode_d = mode_e'(mode_q + 2'd1);
      end
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  always_comb begin
    led_d = '0;
    unique case (mode_q)
      M_SYS:  led_d = sys_reg_q;
      M_CYC:  led_d = cycle_cnt_q;
      M_INST: led_d = inst_cnt_q;
      M_IRQ:  led_d = WIDTH'({irq_cnt_q[15:0], pc[15:0]});
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
      irq_cnt_q   <= '0;
      sys_reg_q   <= '0;
      led_q       <= '0;
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      mode_q      <= M_SYS;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      irq_cnt_q   <= irq_cnt_d;
      sys_reg_q   <= sys_reg_d;
      led_q       <= led_d;
      sync1_q     <= mode_btn;
      btn_s_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      mode_q      <= mode_d;
    end
  end

  assign LedData = led_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_led_data_sel.sv
// Bench for led_data_sel: scoreboard of expected LedData words,
// button press sequences, halt/irq/syscall scenarios.
module tb_led_data_sel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        retire = 1'b0;
  logic        irq_ack = 1'b0;
  logic        sys_wr = 1'b0;
  logic        mode_btn = 1'b0;
  logic [31:0] sys_data = '0;
  logic [31:0] pc = '0;
  logic [31:0] LedData;
  logic [1:0]  mode;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;
  logic [31:0] m_cyc;

  led_data_sel #(.WIDTH(32), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .retire(retire),
    .irq_ack(irq_ack), .sys_wr(sys_wr), .sys_data(sys_data),
    .pc(pc), .mode_btn(mode_btn), .LedData(LedData), .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference cycle counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= '0;
    else if (!halt) m_cyc <= m_cyc + 32'd1;
  end

  task automatic press();
    mode_btn = 1'b1;
    repeat (30) @(negedge clk);
    mode_btn = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (LedData !== 32'h0) begin
      bad++;
      $display("FAIL reset_led: got %h want %h", LedData, 32'h0);
    end
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL reset_mode: got %0d want 0", mode);
    end
    rst_n = 1'b1;
    press();
    total++;
    if (mode !== 2'd1) begin
      bad++;
      $display("FAIL press1_mode: got %0d want 1", mode);
    end
    sb.delete();
    sb.push_back(m_cyc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if (LedData !== exp_v) begin
        bad++;
        $display("FAIL cyc_count[%0d]: got %h want %h", i, LedData, exp_v);
      end
      sb.push_back(m_cyc);
    end
    sb.delete();
  endtask

  task automatic test_halt();
    press();
    total++;
    if (mode !== 2'd2) begin
      bad++;
      $display("FAIL press2_mode: got %0d want 2", mode);
    end
    retire = 1'b1;
    repeat (10) @(negedge clk);
    retire = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      @(negedge clk);
      retire = 1'b0;
      @(negedge clk);
    end
    sb.push_back(32'h0000_000A);
    repeat (3) @(negedge clk);
    exp_v = sb.pop_front();
    total++;
    if (LedData !== exp_v) begin
      bad++;
      $display("FAIL halt_inst: got %h want %h", LedData, exp_v);
    end
    halt = 1'b0;
  endtask

  task automatic test_mode3();
    press();
    pc = 32'h0000_3040;
    for (int i = 0; i < 5; i++) begin
      halt = (i >= 2);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      @(negedge clk);
    end
    halt = 1'b0;
    sb.push_back(32'h0005_3040);
    repeat (3) @(negedge clk);
    exp_v = sb.pop_front();
    total++;
    if (LedData !== exp_v) begin
      bad++;
      $display("FAIL mode3_led: got %h want %h", LedData, exp_v);
    end
    press();
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL mode_wrap: got %0d want 0", mode);
    end
  endtask

  task automatic test_syscall();
    sys_wr = 1'b1;
    sys_data = 32'hDEAD_BEEF;
    sb.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    sys_data = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    @(negedge clk);
    sys_wr = 1'b0;
    sys_data = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      exp_v = sb.pop_front();
      total++;
      if (LedData !== exp_v) begin
        bad++;
        $display("FAIL syscall[%0d]: got %h want %h", i, LedData, exp_v);
      end
      @(negedge clk);
    end
    total++;
    if (LedData !== 32'h1234_5678) begin
      bad++;
      $display("FAIL syscall_hold: got %h want %h", LedData, 32'h1234_5678);
    end
  endtask

  task automatic test_debounce();
    int ch_b;
    int ch_h;
    logic [1:0] prev;
    ch_b = 0;
    ch_h = 0;
    prev = mode;
    for (int i = 0; i < 40; i++) begin
      mode_btn = (((i / 3) % 2) == 0);
      @(negedge clk);
      if (mode !== prev) ch_b++;
      prev = mode;
    end
    mode_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mode !== prev) ch_h++;
      prev = mode;
    end
    total++;
    if (ch_b != 0) begin
      bad++;
      $display("FAIL bounce_changes: got %0d want 0", ch_b);
    end
    total++;
    if (ch_h != 1 || mode !== 2'd1) begin
      bad++;
      $display("FAIL hold_changes: got %0d mode %0d want 1 mode 1", ch_h, mode);
    end
    mode_btn = 1'b0;
    repeat (30) @(negedge clk);
    press();
    total++;
    if (mode !== 2'd2) begin
      bad++;
      $display("FAIL repress_mode: got %0d want 2", mode);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v[6];
    int k;
    press();
    press();
    press();
    total++;
    if (mode !== 2'd1) begin
      bad++;
      $display("FAIL wrap_mode: got %0d want 1", mode);
    end
    sb.delete();
    sb.push_back(m_cyc);
    for (int i = 0; i < 8; i++) begin
      halt = (i >= 2 && i < 5);
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if (LedData !== exp_v) begin
        bad++;
        $display("FAIL halt_cyc[%0d]: got %h want %h", i, LedData, exp_v);
      end
      sb.push_back(m_cyc);
    end
    halt = 1'b0;
    sb.delete();
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_cnt_q;
    v[0] = LedData;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      v[i] = LedData;
    end
    k = -1;
    for (int i = 0; i < 4; i++) begin
      if (k < 0 && v[i] == 32'hFFFF_FFFF && v[i+1] == 32'h0) k = i + 1;
    end
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL wrap_seen: got %h %h %h want ffffffff then 00000000",
               v[0], v[1], v[2]);
    end else begin
      total++;
      if (v[k+1] !== 32'h1) begin
        bad++;
        $display("FAIL wrap_next: got %h want %h", v[k+1], 32'h1);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode_btn = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL midrst_mode: got %0d want 0", mode);
    end
    total++;
    if (LedData !== 32'h0) begin
      bad++;
      $display("FAIL midrst_led: got %h want %h", LedData, 32'h0);
    end
    repeat (3) @(negedge clk);
    mode_btn = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (mode !== 2'd0 || LedData !== 32'h0) begin
      bad++;
      $display("FAIL post_rst: got mode %0d led %h want 0 0", mode, LedData);
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_mode3();
    test_syscall();
    test_debounce();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
